core_lsu_wport: RTL and testbench

// Write/refill port of the data cache, at the opposite end of the rport<->wport interface to the M2 read port.
// - Consumes rport requests: refill, uncached read/write, hit write, direct invalidate.
// - Drives the tag/data RAM write requests (wreq) and the wport status back to the rport (wstate).
// - Owns a single-outstanding, line-burst memory bus master.

---
 rtl/core_lsu_wport.sv | 138 +++++++++++++
 tb/tb_core_lsu_wport.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu_wport.sv
// core_lsu_wport: data cache write/refill port with a single-outstanding line-burst bus master
module core_lsu_wport #(
    parameter int WAY_CNT    = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refill_valid_i,
    input  logic                  uc_read_i,
    input  logic                  uc_write_valid_i,
    input  logic                  inv_valid_i,
    input  logic                  hit_write_i,
    input  logic [WAY_CNT-1:0]    wsel_i,
    input  logic [31:0]           addr_i,
    input  logic [1:0]            rwsize_i,
    input  logic [3:0]            wstrobe_i,
    input  logic [31:0]           wdata_i,
    input  logic [WAY_CNT*21-1:0] tag_rdata_i,
    output logic                  uop_ready_o,
    output logic                  read_ready_o,
    output logic [31:0]           rdata_o,
    output logic                  uc_write_ready_o,
    output logic [WAY_CNT-1:0]    tag_we_o,
    output logic [7:0]            tag_waddr_o,
    output logic [20:0]           tag_wdata_o,
    output logic [WAY_CNT*4-1:0]  data_we_o,
    output logic [9:0]            data_waddr_o,
    output logic [31:0]           data_wdata_o,
    output logic                  bus_req_valid_o,
    input  logic                  bus_req_ready_i,
    output logic                  bus_req_write_o,
    output logic [31:0]           bus_req_addr_o,
    output logic [1:0]            bus_req_size_o,
    output logic [7:0]            bus_req_len_o,
    output logic [31:0]           bus_wdata_o,
    output logic [3:0]            bus_wstrb_o,
    input  logic                  bus_rvalid_i,
    input  logic [31:0]           bus_rdata_i,
    input  logic                  bus_rlast_i,
    input  logic                  bus_bvalid_i
);
    localparam int TW = 21;
    localparam int VW = WAY_CNT > 1 ? $clog2(WAY_CNT) : 1;

    typedef enum logic [2:0] {IDLE, RF_REQ, RF_DATA, UR_REQ, UR_DATA, UW_REQ, UW_RESP, INV} state_t;

    state_t        state;
    logic [VW-1:0] vcnt, vcnt_nxt, vic, vic_pick;
    logic [1:0]    beat, size_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    strb_q;
    logic          hit, rf_beat, rf_last, ur_done, rq_rf, rq_ur, rq_uw;
    logic          unused;

    assign unused = ^tag_rdata_i;
    assign vcnt_nxt = (vcnt == VW'(WAY_CNT - 1)) ? '0 : vcnt + 1'b1;

    // lowest invalid way wins; with every way valid fall back to round-robin
    always_comb begin
        vic_pick = vcnt;
        for (int w = WAY_CNT - 1; w >= 0; w--)
            if (!tag_rdata_i[w*TW+TW-1]) vic_pick = VW'(w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            vcnt    <= '0;
            vic     <= '0;
            beat    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr_q  <= addr_i;
                    size_q  <= rwsize_i;
                    wdata_q <= wdata_i;
                    strb_q  <= wstrobe_i;
                    beat    <= '0;
                    vic     <= vic_pick;
                    state   <= inv_valid_i ? INV : refill_valid_i ? RF_REQ : uc_read_i ? UR_REQ :
                               uc_write_valid_i ? UW_REQ : IDLE;
                end
                RF_REQ:  if (bus_req_ready_i) state <= RF_DATA;
                RF_DATA: if (bus_rvalid_i) begin
                    beat <= beat + 2'd1;
                    if (bus_rlast_i) begin
                        state <= IDLE;
                        vcnt  <= vcnt_nxt;
                    end
                end
                UR_REQ:  if (bus_req_ready_i) state <= UR_DATA;
                UR_DATA: if (bus_rvalid_i) state <= IDLE;
                UW_REQ:  if (bus_req_ready_i) state <= UW_RESP;
                UW_RESP: if (bus_bvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hit     = state == IDLE && hit_write_i;
    assign rf_beat = state == RF_DATA && bus_rvalid_i;
    assign rf_last = rf_beat && bus_rlast_i;
    assign ur_done = state == UR_DATA && bus_rvalid_i;
    assign rq_rf   = state == RF_REQ;
    assign rq_ur   = state == UR_REQ;
    assign rq_uw   = state == UW_REQ;

    assign read_ready_o     = (rf_beat && beat == addr_q[3:2]) || ur_done;
    assign rdata_o          = read_ready_o ? bus_rdata_i : '0;
    assign uop_ready_o      = rf_last || ur_done || state == INV;
    assign uc_write_ready_o = rq_uw && bus_req_ready_i;

    always_comb begin
        for (int w = 0; w < WAY_CNT; w++) begin
            tag_we_o[w]        = state == INV || (rf_last && vic == VW'(w));
            data_we_o[w*4 +: 4] = hit ? {4{wsel_i[w]}} & wstrobe_i : (rf_beat && vic == VW'(w)) ? 4'hF : 4'h0;
        end
    end

    assign tag_waddr_o  = (state == INV || rf_last) ? addr_q[11:4] : '0;
    assign tag_wdata_o  = rf_last ? {1'b1, addr_q[31:12]} : '0;
    assign data_waddr_o = hit ? addr_i[11:2] : rf_beat ? {addr_q[11:4], beat} : '0;
    assign data_wdata_o = hit ? wdata_i : rf_beat ? bus_rdata_i : '0;

    assign bus_req_valid_o = rq_rf || rq_ur || rq_uw;
    assign bus_req_write_o = rq_uw;
    assign bus_req_addr_o  = rq_rf ? {addr_q[31:4], 4'b0} : (rq_ur || rq_uw) ? addr_q : '0;
    assign bus_req_size_o  = rq_rf ? 2'd2 : (rq_ur || rq_uw) ? size_q : '0;
    assign bus_req_len_o   = rq_rf ? 8'(LINE_WORDS - 1) : '0;
    assign bus_wdata_o     = rq_uw ? wdata_q : '0;
    assign bus_wstrb_o     = rq_uw ? strb_q : '0;

    a_hit_idle: assert property (@(posedge clk) disable iff (rst) hit_write_i |-> state == IDLE);
endmodule

// File: tb/tb_core_lsu_wport.sv
// tb_core_lsu_wport: directed vectors and hand sequences for the cache write/refill port
module tb_core_lsu_wport;
    logic        clk, rst;
    logic        refill_valid_i, uc_read_i, uc_write_valid_i, inv_valid_i, hit_write_i;
    logic [1:0]  wsel_i, rwsize_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrobe_i;
    logic [41:0] tag_rdata_i;
    logic        uop_ready_o, read_ready_o, uc_write_ready_o;
    logic [31:0] rdata_o;
    logic [1:0]  tag_we_o;
    logic [7:0]  tag_waddr_o;
    logic [20:0] tag_wdata_o;
    logic [7:0]  data_we_o;
    logic [9:0]  data_waddr_o;
    logic [31:0] data_wdata_o;
    logic        bus_req_valid_o, bus_req_ready_i, bus_req_write_o;
    logic [31:0] bus_req_addr_o, bus_wdata_o, bus_rdata_i;
    logic [1:0]  bus_req_size_o;
    logic [7:0]  bus_req_len_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_rvalid_i, bus_rlast_i, bus_bvalid_i;
    int          errors = 0, checks = 0;

    core_lsu_wport dut (
        .clk(clk), .rst(rst),
        .refill_valid_i(refill_valid_i), .uc_read_i(uc_read_i), .uc_write_valid_i(uc_write_valid_i),
        .inv_valid_i(inv_valid_i), .hit_write_i(hit_write_i), .wsel_i(wsel_i), .addr_i(addr_i),
        .rwsize_i(rwsize_i), .wstrobe_i(wstrobe_i), .wdata_i(wdata_i), .tag_rdata_i(tag_rdata_i),
        .uop_ready_o(uop_ready_o), .read_ready_o(read_ready_o), .rdata_o(rdata_o),
        .uc_write_ready_o(uc_write_ready_o), .tag_we_o(tag_we_o), .tag_waddr_o(tag_waddr_o),
        .tag_wdata_o(tag_wdata_o), .data_we_o(data_we_o), .data_waddr_o(data_waddr_o),
        .data_wdata_o(data_wdata_o), .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
        .bus_req_write_o(bus_req_write_o), .bus_req_addr_o(bus_req_addr_o), .bus_req_size_o(bus_req_size_o),
        .bus_req_len_o(bus_req_len_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_rlast_i(bus_rlast_i),
        .bus_bvalid_i(bus_bvalid_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        refill_valid_i = 0; uc_read_i = 0; uc_write_valid_i = 0; inv_valid_i = 0; hit_write_i = 0;
        wsel_i = 0; rwsize_i = 0; addr_i = 0; wdata_i = 0; wstrobe_i = 0; tag_rdata_i = 0;
        bus_req_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_rlast_i = 0; bus_bvalid_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic refill(input logic [31:0] a, input logic [41:0] tags, input logic [1:0] ev);
        addr_i = a; tag_rdata_i = tags; refill_valid_i = 1;
        step();
        tag_rdata_i = '0;
        bus_req_ready_i = 1;
        #1;
        chk("rf_req_valid", bus_req_valid_o, 1);
        chk("rf_req_addr", bus_req_addr_o, {a[31:4], 4'b0});
        chk("rf_req_len", bus_req_len_o, 3);
        chk("rf_req_size", bus_req_size_o, 2);
        chk("rf_req_write", bus_req_write_o, 0);
        step();
        bus_req_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            bus_rvalid_i = 1; bus_rdata_i = 32'hA000_0000 + 32'(k); bus_rlast_i = (k == 3);
            #1;
            chk("rf_data_we", data_we_o, {{4{ev[1]}}, {4{ev[0]}}});
            chk("rf_data_waddr", data_waddr_o, {a[11:4], 2'(k)});
            chk("rf_data_wdata", data_wdata_o, 32'hA000_0000 + 32'(k));
            chk("rf_read_ready", read_ready_o, 2'(k) == a[3:2]);
            if (2'(k) == a[3:2]) chk("rf_rdata", rdata_o, 32'hA000_0000 + 32'(k));
            chk("rf_tag_we", tag_we_o, k == 3 ? ev : 2'b00);
            chk("rf_uop_ready", uop_ready_o, k == 3);
            if (k == 3) begin
                chk("rf_tag_waddr", tag_waddr_o, a[11:4]);
                chk("rf_tag_wdata", tag_wdata_o, {1'b1, a[31:12]});
            end
            step();
        end
        bus_rvalid_i = 0; bus_rlast_i = 0; refill_valid_i = 0;
        #1;
        chk("rf_back_idle", bus_req_valid_o, 0);
    endtask

    typedef struct {
        logic        hit;
        logic [1:0]  wsel;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [7:0]  we;
        logic [9:0]  waddr;
    } hv_t;

    hv_t hv[5];

    initial begin
        hv[0] = '{1'b1, 2'b10, 32'h0000_0108, 4'hC, 32'hDEAD_BEEF, 8'hC0, 10'h042};
        hv[1] = '{1'b1, 2'b01, 32'h0000_0FFC, 4'hF, 32'h0102_0304, 8'h0F, 10'h3FF};
        hv[2] = '{1'b1, 2'b11, 32'h8000_0004, 4'h5, 32'h5555_AAAA, 8'h55, 10'h001};
        hv[3] = '{1'b1, 2'b00, 32'h0000_0010, 4'hF, 32'h1234_5678, 8'h00, 10'h004};
        hv[4] = '{1'b0, 2'b11, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 8'h00, 10'h000};
        rst = 1;
        clear_inputs();
        step();
        #1;
        chk("rst_uop_ready", uop_ready_o, 0);
        chk("rst_bus_valid", bus_req_valid_o, 0);
        chk("rst_tag_we", tag_we_o, 0);
        chk("rst_data_we", data_we_o, 0);
        chk("rst_read_ready", read_ready_o, 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            hit_write_i = hv[i].hit; wsel_i = hv[i].wsel; addr_i = hv[i].addr;
            wstrobe_i = hv[i].strb; wdata_i = hv[i].wdata;
            #1;
            chk("hit_we", data_we_o, hv[i].we);
            if (hv[i].hit) begin
                chk("hit_waddr", data_waddr_o, hv[i].waddr);
                chk("hit_wdata", data_wdata_o, hv[i].wdata);
            end
            chk("hit_no_bus", bus_req_valid_o, 0);
            step();
            hit_write_i = 0;
            #1;
            chk("hit_still_idle", bus_req_valid_o, 0);
        end

        do_reset();
        refill(32'h8000_1238, 42'h0, 2'b01);

        do_reset();
        refill(32'h0000_0100, {1'b1, 20'h0, 1'b1, 20'h0}, 2'b01);
        refill(32'h0000_0200, {1'b1, 20'h0, 1'b1, 20'h0}, 2'b10);
        refill(32'h0000_0300, {1'b1, 20'h0, 1'b1, 20'h0}, 2'b01);
        refill(32'h0000_0404, {1'b0, 20'h0, 1'b1, 20'h0}, 2'b10);

        do_reset();
        addr_i = 32'h1FD0_0004; rwsize_i = 2; uc_read_i = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ur_stall_valid", bus_req_valid_o, 1);
            chk("ur_stall_addr", bus_req_addr_o, 32'h1FD0_0004);
            chk("ur_stall_size", bus_req_size_o, 2);
            chk("ur_stall_len", bus_req_len_o, 0);
            chk("ur_stall_write", bus_req_write_o, 0);
            step();
        end
        bus_req_ready_i = 1;
        #1;
        chk("ur_hs_addr", bus_req_addr_o, 32'h1FD0_0004);
        step();
        bus_req_ready_i = 0;
        #1;
        chk("ur_wait_rr", read_ready_o, 0);
        chk("ur_wait_valid", bus_req_valid_o, 0);
        step();
        bus_rvalid_i = 1; bus_rdata_i = 32'h1234_5678; bus_rlast_i = 1;
        #1;
        chk("ur_read_ready", read_ready_o, 1);
        chk("ur_uop_ready", uop_ready_o, 1);
        chk("ur_rdata", rdata_o, 32'h1234_5678);
        chk("ur_no_data_we", data_we_o, 0);
        step();
        bus_rvalid_i = 0; bus_rlast_i = 0; uc_read_i = 0;
        #1;
        chk("ur_idle_rr", read_ready_o, 0);

        do_reset();
        addr_i = 32'h1FD0_0010; rwsize_i = 1; wdata_i = 32'hAABB_CCDD; wstrobe_i = 4'b0011; uc_write_valid_i = 1;
        step();
        #1;
        chk("uw_valid", bus_req_valid_o, 1);
        chk("uw_write", bus_req_write_o, 1);
        chk("uw_wdata", bus_wdata_o, 32'hAABB_CCDD);
        chk("uw_wstrb", bus_wstrb_o, 4'b0011);
        chk("uw_addr", bus_req_addr_o, 32'h1FD0_0010);
        chk("uw_ready_early", uc_write_ready_o, 0);
        bus_req_ready_i = 1;
        #1;
        chk("uw_ready_hs", uc_write_ready_o, 1);
        step();
        bus_req_ready_i = 0; wdata_i = 32'h1122_3344; wstrobe_i = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("uw_resp_ready", uc_write_ready_o, 0);
            chk("uw_resp_valid", bus_req_valid_o, 0);
            step();
        end
        bus_bvalid_i = 1;
        step();
        bus_bvalid_i = 0;
        #1;
        chk("uw_idle_valid", bus_req_valid_o, 0);
        step();
        #1;
        chk("uw2_valid", bus_req_valid_o, 1);
        chk("uw2_wdata", bus_wdata_o, 32'h1122_3344);
        bus_req_ready_i = 1;
        #1;
        chk("uw2_ready", uc_write_ready_o, 1);
        step();
        bus_req_ready_i = 0; uc_write_valid_i = 0; bus_bvalid_i = 1;
        step();
        bus_bvalid_i = 0;

        do_reset();
        addr_i = 32'h0000_0AB0; inv_valid_i = 1; refill_valid_i = 1;
        step();
        #1;
        chk("inv_tag_we", tag_we_o, 2'b11);
        chk("inv_tag_waddr", tag_waddr_o, 8'hAB);
        chk("inv_tag_wdata", tag_wdata_o, 0);
        chk("inv_uop_ready", uop_ready_o, 1);
        chk("inv_no_bus", bus_req_valid_o, 0);
        inv_valid_i = 0; refill_valid_i = 0;
        step();
        #1;
        chk("inv_done_tag_we", tag_we_o, 0);
        chk("inv_done_uop", uop_ready_o, 0);

        do_reset();
        addr_i = 32'h8000_1238; refill_valid_i = 1; bus_req_ready_i = 1;
        step();
        step();
        bus_req_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hB0; bus_rlast_i = 0;
        step();
        bus_rdata_i = 32'hB1; rst = 1;
        step();
        rst = 0; refill_valid_i = 0; bus_rdata_i = 32'hB2; bus_rlast_i = 1;
        #1;
        chk("rstmid_tag_we", tag_we_o, 0);
        chk("rstmid_bus_valid", bus_req_valid_o, 0);
        chk("rstmid_data_we", data_we_o, 0);
        chk("rstmid_uop", uop_ready_o, 0);
        bus_rvalid_i = 0; bus_rlast_i = 0;
        step();
        #1;
        chk("rstmid_idle", bus_req_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
